// File: rtl/lsu_mem_port.sv
// lsu_mem_port
//
// Responder end of the execute-stage load/store interface. Accepts one aligned
// 64-bit load or store request, checks that it falls inside the backing-memory
// window, runs it on a valid/ready memory bus, and returns the result with a
// one-cycle low pulse on lsu_stall_next.
//
// Parameters
//   ADDR_W    width of the 8-byte-aligned word address
//   XLEN      data width (64)
//   MEM_BASE  first valid aligned word address
//   MEM_WORDS number of valid words starting at MEM_BASE
//   TIMEOUT   WAIT cycles without a bus response before faulting (>= 1)
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   lsu_prev_stalled               low: a request is presented this cycle
//   lsu_addr                       aligned word address
//   lsu_do_load / lsu_do_store     request kind (complementary)
//   lsu_store_data / _mask         lane-replicated store data and byte enables
//   lsu_stall_next                 low for one cycle when the response is valid
//   lsu_load_data                  load result (0 for stores and faults)
//   lsu_access_fault               range fault, bus error or timeout
//   mem_req_*                      backing-memory request channel
//   mem_resp_*                     backing-memory response channel
//
// All outputs come straight from flops.

`timescale 1ns / 1ps

module lsu_mem_port #(
  parameter int unsigned        ADDR_W    = 29,
  parameter int unsigned        XLEN      = 64,
  parameter logic [ADDR_W-1:0]  MEM_BASE  = '0,
  parameter longint unsigned    MEM_WORDS = 64'd1 << 16,
  parameter int unsigned        TIMEOUT   = 255
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                lsu_prev_stalled,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_do_load,
  input  logic                lsu_do_store,
  input  logic [XLEN-1:0]     lsu_store_data,
  input  logic [XLEN/8-1:0]   lsu_store_mask,
  output logic                lsu_stall_next,
  output logic [XLEN-1:0]     lsu_load_data,
  output logic                lsu_access_fault,

  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_write,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [XLEN-1:0]     mem_req_wdata,
  output logic [XLEN/8-1:0]   mem_req_wmask,
  input  logic                mem_resp_valid,
  input  logic [XLEN-1:0]     mem_resp_rdata,
  input  logic                mem_resp_error
);

  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic [XLEN/8-1:0]   wmask_q, wmask_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                stale_q, stale_d;
  logic                fault_q, fault_d;
  logic [XLEN-1:0]     rdata_q, rdata_d;
  logic                stall_q, stall_d;
  logic                req_valid_q, req_valid_d;

  logic [ADDR_W-1:0]   offset;
  logic                out_of_range;
  logic                resp_usable;

  // Subtracting at ADDR_W bits makes addresses below MEM_BASE wrap to huge
  // offsets, so they land out of range with the same single compare.
  assign offset       = lsu_addr - MEM_BASE;
  assign out_of_range = 64'(offset) >= MEM_WORDS;

  // A response arriving while a timed-out access is still outstanding belongs
  // to that old access and must never be credited to the current one.
  assign resp_usable  = mem_resp_valid && !stale_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    cnt_d       = cnt_q;
    stale_d     = stale_q;
    fault_d     = fault_q;
    rdata_d     = rdata_q;

    // Stale drop is independent of state.
    if (mem_resp_valid && stale_q) begin
      stale_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (!lsu_prev_stalled) begin
          addr_d  = lsu_addr;
          write_d = lsu_do_store;
          wdata_d = lsu_store_data;
          wmask_d = lsu_store_mask;
          if (out_of_range) begin
            state_d = StResp;
            fault_d = 1'b1;
            rdata_d = '0;
          end else if (lsu_do_store && (lsu_store_mask == '0)) begin
            // Nothing to write: complete locally without touching the bus.
            state_d = StResp;
            fault_d = 1'b0;
            rdata_d = '0;
          end else begin
            state_d = StReq;
          end
        end
      end

      StReq: begin
        if (mem_req_ready) begin
          state_d = StWait;
          cnt_d   = '0;
        end
      end

      StWait: begin
        cnt_d = cnt_q + CntW'(1);
        if (resp_usable) begin
          state_d = StResp;
          fault_d = mem_resp_error;
          rdata_d = (write_q || mem_resp_error) ? '0 : mem_resp_rdata;
        end else if (cnt_d == CntW'(TIMEOUT)) begin
          // The memory may still answer later; remember to swallow that reply.
          state_d = StResp;
          fault_d = 1'b1;
          rdata_d = '0;
          stale_d = 1'b1;
        end
      end

      StResp: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Registered versions of the state decodes keep every output on a flop.
    stall_d     = (state_d != StResp);
    req_valid_d = (state_d == StReq);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      cnt_q       <= '0;
      stale_q     <= 1'b0;
      fault_q     <= 1'b0;
      rdata_q     <= '0;
      stall_q     <= 1'b1;
      req_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      cnt_q       <= cnt_d;
      stale_q     <= stale_d;
      fault_q     <= fault_d;
      rdata_q     <= rdata_d;
      stall_q     <= stall_d;
      req_valid_q <= req_valid_d;
    end
  end

  assign lsu_stall_next   = stall_q;
  assign lsu_load_data    = rdata_q;
  assign lsu_access_fault = fault_q;

  assign mem_req_valid    = req_valid_q;
  assign mem_req_write    = write_q;
  assign mem_req_addr     = addr_q;
  assign mem_req_wdata    = wdata_q;
  assign mem_req_wmask    = wmask_q;

  // Upstream must hold off while a transaction is in flight; such requests
  // are dropped by the FSM above.
  a_req_only_in_idle: assert property (
    @(posedge clk) disable iff (rst) !lsu_prev_stalled |-> (state_q == StIdle)
  ) else $error("lsu_mem_port: request presented outside IDLE");

  a_load_store_exclusive: assert property (
    @(posedge clk) disable iff (rst) !lsu_prev_stalled |-> (lsu_do_load != lsu_do_store)
  ) else $error("lsu_mem_port: lsu_do_load and lsu_do_store not complementary");

endmodule

// File: tb/tb_lsu_mem_port.sv
// Randomized self-checking bench for lsu_mem_port. The bench plays the role of
// both the memory execution unit and the backing memory, and predicts each
// response (cycle, fault, data) from the transaction-level rules.

`timescale 1ns / 1ps

module tb_lsu_mem_port;

  localparam int unsigned       ADDR_W    = 29;
  localparam int unsigned       XLEN      = 64;
  localparam logic [ADDR_W-1:0] MEM_BASE  = 29'h0000_1000;
  localparam longint unsigned   MEM_WORDS = 64'd1 << 16;
  localparam int unsigned       TIMEOUT   = 255;

  logic                clk = 1'b0;
  logic                rst;
  logic                lsu_prev_stalled;
  logic [ADDR_W-1:0]   lsu_addr;
  logic                lsu_do_load;
  logic                lsu_do_store;
  logic [XLEN-1:0]     lsu_store_data;
  logic [XLEN/8-1:0]   lsu_store_mask;
  logic                lsu_stall_next;
  logic [XLEN-1:0]     lsu_load_data;
  logic                lsu_access_fault;
  logic                mem_req_valid;
  logic                mem_req_ready;
  logic                mem_req_write;
  logic [ADDR_W-1:0]   mem_req_addr;
  logic [XLEN-1:0]     mem_req_wdata;
  logic [XLEN/8-1:0]   mem_req_wmask;
  logic                mem_resp_valid;
  logic [XLEN-1:0]     mem_resp_rdata;
  logic                mem_resp_error;

  int n_vec = 0;
  int n_err = 0;
  bit stale_m = 1'b0;  // a timed-out access may still be answered

  lsu_mem_port #(
    .ADDR_W    (ADDR_W),
    .XLEN      (XLEN),
    .MEM_BASE  (MEM_BASE),
    .MEM_WORDS (MEM_WORDS),
    .TIMEOUT   (TIMEOUT)
  ) u_dut (
    .clk              (clk),
    .rst              (rst),
    .lsu_prev_stalled (lsu_prev_stalled),
    .lsu_addr         (lsu_addr),
    .lsu_do_load      (lsu_do_load),
    .lsu_do_store     (lsu_do_store),
    .lsu_store_data   (lsu_store_data),
    .lsu_store_mask   (lsu_store_mask),
    .lsu_stall_next   (lsu_stall_next),
    .lsu_load_data    (lsu_load_data),
    .lsu_access_fault (lsu_access_fault),
    .mem_req_valid    (mem_req_valid),
    .mem_req_ready    (mem_req_ready),
    .mem_req_write    (mem_req_write),
    .mem_req_addr     (mem_req_addr),
    .mem_req_wdata    (mem_req_wdata),
    .mem_req_wmask    (mem_req_wmask),
    .mem_resp_valid   (mem_resp_valid),
    .mem_resp_rdata   (mem_resp_rdata),
    .mem_resp_error   (mem_resp_error)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_stall"}, lsu_stall_next, 1'b1);
    check_eq({tag, "_req_valid"}, mem_req_valid, 1'b0);
    check_eq({tag, "_data"}, lsu_load_data, 64'h0);
    check_eq({tag, "_fault"}, lsu_access_fault, 1'b0);
  endtask

  // Entered #1 after a rising edge in an IDLE cycle; returns the same way.
  // Cycle k counts cycles after the accepting edge; the memory is ready at
  // cycle 1+rdly, answers wdly cycles into WAIT, optionally with an extra
  // early answer and/or a stray answer during REQ.
  task automatic run_txn(input logic [ADDR_W-1:0] addr, input bit st,
                         input logic [63:0] wd, input logic [7:0] wm,
                         input int rdly, input int wdly, input bit err,
                         input bit no_resp, input bit early_dup, input bit stray,
                         input logic [63:0] rd);
    logic [ADDR_W-1:0] off;
    bit                inr, bus, done, rv, exp_f;
    int                r, exp_k;
    logic [63:0]       exp_d;
    off   = addr - MEM_BASE;
    inr   = 64'(off) < MEM_WORDS;
    bus   = inr && !(st && (wm == 8'h00));
    r     = 1 + rdly;
    exp_k = 0;
    exp_f = 1'b0;
    exp_d = 64'h0;
    done  = 1'b0;
    if (!bus) begin
      exp_k = 1;
      exp_f = !inr;
    end

    lsu_prev_stalled = 1'b0;
    lsu_addr         = addr;
    lsu_do_store     = st;
    lsu_do_load      = !st;
    lsu_store_data   = wd;
    lsu_store_mask   = wm;
    @(posedge clk); #1;
    lsu_prev_stalled = 1'b1;
    lsu_addr         = ADDR_W'($urandom);
    lsu_store_data   = {$urandom, $urandom};
    lsu_store_mask   = 8'($urandom);

    for (int k = 1; k <= int'(TIMEOUT) + rdly + 8 && !done; k++) begin
      rv = 1'b0;
      if (bus) begin
        if (stray && k == 1) rv = 1'b1;
        if (early_dup && k == r + 1) rv = 1'b1;
        if (!no_resp && k == r + 1 + wdly) rv = 1'b1;
      end
      mem_req_ready  = bus && (k == r);
      mem_resp_valid = rv;
      mem_resp_rdata = (k > r) ? rd : {$urandom, $urandom};
      mem_resp_error = (k > r) ? err : 1'b1;

      if (rv) begin
        if (stale_m) begin
          stale_m = 1'b0;
        end else if (k > r && exp_k == 0) begin
          exp_k = k + 1;
          exp_f = err;
          exp_d = (st || err) ? 64'h0 : rd;
        end
      end
      if (bus && exp_k == 0 && k == r + int'(TIMEOUT)) begin
        exp_k   = k + 1;
        exp_f   = 1'b1;
        exp_d   = 64'h0;
        stale_m = 1'b1;
      end

      @(negedge clk);
      check_eq("req_valid", mem_req_valid, bus && (k <= r));
      if (bus && k <= r) begin
        check_eq("req_addr", mem_req_addr, addr);
        check_eq("req_write", mem_req_write, st);
        check_eq("req_wdata", mem_req_wdata, wd);
        check_eq("req_wmask", mem_req_wmask, wm);
      end
      check_eq("stall", lsu_stall_next, k != exp_k);
      if (k == exp_k) begin
        check_eq("fault", lsu_access_fault, exp_f);
        check_eq("load_data", lsu_load_data, exp_d);
        done = 1'b1;
      end else if (!lsu_stall_next) begin
        done = 1'b1;
      end
      if (!done) begin
        @(posedge clk); #1;
      end
    end
    if (!done) check_eq("resp_seen", 1'b0, 1'b1);
    @(posedge clk); #1;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_error = 1'b0;
  endtask

  // Drop a load in the middle of WAIT with an asynchronous reset.
  task automatic reset_mid_wait();
    lsu_prev_stalled = 1'b0;
    lsu_addr         = MEM_BASE + 29'd7;
    lsu_do_store     = 1'b0;
    lsu_do_load      = 1'b1;
    @(posedge clk); #1;
    lsu_prev_stalled = 1'b1;
    mem_req_ready    = 1'b1;
    @(posedge clk); #1;
    mem_req_ready    = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_idle_outputs("async_rst");
    @(posedge clk); #1;
    rst     = 1'b0;
    stale_m = 1'b0;
    for (int k = 0; k < 6; k++) begin
      mem_resp_valid = (k == 1);
      mem_resp_rdata = {$urandom, $urandom};
      @(negedge clk);
      check_eq("post_rst_stall", lsu_stall_next, 1'b1);
      check_eq("post_rst_req_valid", mem_req_valid, 1'b0);
      @(posedge clk); #1;
    end
    mem_resp_valid = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_W-1:0] a;
    int                sel;
    rst              = 1'b1;
    lsu_prev_stalled = 1'b1;
    lsu_addr         = '0;
    lsu_do_load      = 1'b1;
    lsu_do_store     = 1'b0;
    lsu_store_data   = '0;
    lsu_store_mask   = '0;
    mem_req_ready    = 1'b0;
    mem_resp_valid   = 1'b0;
    mem_resp_rdata   = '0;
    mem_resp_error   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // addr, st, wdata, wmask, rdly, wdly, err, no_resp, early_dup, stray, rdata
    run_txn(MEM_BASE + 29'd5, 0, 64'h0, 8'hFF, 0, 0, 0, 0, 0, 0, 64'h1122334455667788);
    run_txn(MEM_BASE + 29'd9, 1, 64'hAABBCCDDAABBCCDD, 8'h0F, 4, 0, 0, 0, 0, 0, 64'hDEAD);
    run_txn(MEM_BASE + ADDR_W'(MEM_WORDS), 0, 64'h0, 8'hFF, 0, 0, 0, 0, 0, 0, 64'h1);
    run_txn(MEM_BASE - 29'd1, 0, 64'h0, 8'hFF, 0, 0, 0, 0, 0, 0, 64'h2);
    run_txn(MEM_BASE + ADDR_W'(MEM_WORDS) - 29'd1, 0, 64'h0, 8'hFF, 1, 1, 0, 0, 0, 0,
            64'h0123456789ABCDEF);
    run_txn(MEM_BASE + 29'd3, 0, 64'h0, 8'hFF, 0, 2, 1, 0, 0, 1, 64'h5555AAAA5555AAAA);
    run_txn(MEM_BASE + 29'd4, 0, 64'h0, 8'hFF, 0, 0, 0, 1, 0, 0, 64'h3);
    run_txn(MEM_BASE + 29'd6, 0, 64'h0, 8'hFF, 0, 2, 0, 0, 1, 0, 64'hCAFEF00DCAFEF00D);
    reset_mid_wait();
    run_txn(MEM_BASE + 29'd8, 1, 64'h77, 8'h00, 0, 0, 0, 0, 0, 0, 64'h4);

    for (int i = 0; i < 60; i++) begin
      sel = int'($urandom_range(0, 7));
      case (sel)
        0:       a = MEM_BASE + ADDR_W'(MEM_WORDS) + ADDR_W'($urandom_range(0, 99));
        1:       a = MEM_BASE - 29'd1 - ADDR_W'($urandom_range(0, 99));
        2:       a = ADDR_W'($urandom);
        default: a = MEM_BASE + ADDR_W'($urandom_range(0, 32'(MEM_WORDS) - 1));
      endcase
      run_txn(a, 1'($urandom), {$urandom, $urandom},
              ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom),
              int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
              $urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0,
              1'($urandom), $urandom_range(0, 3) == 0, {$urandom, $urandom});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
